// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one request outstanding to imem and holds the word for decode.
// Define FETCH_ALIGN_CHK_EN to trap misaligned redirect targets in a sticky FAULT state.
module fetch_unit #(
    parameter int                XLEN      = 32,
    parameter logic [XLEN-1:0]   RESET_PC  = '0,
    parameter logic [31:0]       NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    output logic            fetch_fault
);

    typedef enum logic [2:0] {
        REQ,
        WAIT,
        OUT,
        DROP
`ifdef FETCH_ALIGN_CHK_EN
        , FAULT
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] target;

`ifdef FETCH_ALIGN_CHK_EN
    logic fault_q, fault_d;
    logic pend_q, pend_d;
    logic misaligned;

    assign target     = redirect_target;
    assign misaligned = (redirect_target[1:0] != 2'b00);
`else
    assign target = redirect_target & ~{{(XLEN-2){1'b0}}, 2'b11};
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
`ifdef FETCH_ALIGN_CHK_EN
        fault_d = fault_q;
        pend_d  = pend_q;
`endif
        case (state_q)
            REQ: begin
                if (redirect) begin
                    pc_d = target;
                    if (imem_gnt) state_d = DROP;
                end else if (imem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = imem_rvalid ? REQ : DROP;
                end else if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (redirect) begin
                    pc_d    = target;
                    instr_d = NOP_INSTR;
                    state_d = REQ;
                end else if (instr_ready) begin
                    pc_d    = pc_q + XLEN'(4);
                    instr_d = NOP_INSTR;
                    state_d = REQ;
                end
            end
            DROP: begin
                if (redirect) pc_d = target;
                if (imem_rvalid) state_d = REQ;
            end
`ifdef FETCH_ALIGN_CHK_EN
            FAULT: begin
                if (imem_rvalid) pend_d = 1'b0;
                if (redirect) begin
                    pc_d    = target;
                    fault_d = 1'b0;
                    state_d = (pend_q && !imem_rvalid) ? DROP : REQ;
                end
            end
`endif
            default: state_d = REQ;
        endcase
`ifdef FETCH_ALIGN_CHK_EN
        // A misaligned target overrides everything but must remember a response still owed by memory.
        if (redirect && misaligned) begin
            state_d = FAULT;
            fault_d = 1'b1;
            pc_d    = redirect_target;
            instr_d = NOP_INSTR;
            case (state_q)
                REQ:         pend_d = imem_gnt;
                WAIT, DROP:  pend_d = !imem_rvalid;
                FAULT:       pend_d = pend_q && !imem_rvalid;
                default:     pend_d = 1'b0;
            endcase
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
`ifdef FETCH_ALIGN_CHK_EN
            fault_q <= 1'b0;
            pend_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
`ifdef FETCH_ALIGN_CHK_EN
            fault_q <= fault_d;
            pend_q  <= pend_d;
`endif
        end
    end

    assign imem_req    = (state_q == REQ) && !reset;
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == OUT);
    assign instr       = instr_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + XLEN'(4);
`ifdef FETCH_ALIGN_CHK_EN
    assign fetch_fault = fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized memory timing, stalls, redirects and resets.
// A monitor checks every delivered instruction against a transaction-level PC stream model.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        fetch_fault;

    int checks = 0;
    int fails = 0;
    int handshakes = 0;

    // Memory model: one outstanding access, grant after gnt_wait cycles, data rv_lat cycles after earliest.
    int          gnt_wait = 0;
    int          rv_lat = 0;
    int          req_age = 0;
    logic        mem_pending = 1'b0;
    logic [31:0] mem_addr = '0;
    int          mem_cnt = 0;

    logic [31:0] exp_q[$];
    logic        prev_req = 1'b0, prev_gnt = 1'b0, prev_redirect = 1'b0, prev_reset = 1'b1;
    logic [31:0] prev_addr = '0;

    fetch_unit dut (
        .clk(clk),
        .reset(reset),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr(instr),
        .pc(pc),
        .pc_plus4(pc_plus4),
        .redirect(redirect),
        .redirect_target(redirect_target),
        .fetch_fault(fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_gnt = imem_req && !mem_pending && (req_age >= gnt_wait);

    function automatic logic [31:0] memword(input logic [31:0] a);
        return 32'h0050_0093 ^ (a * 32'h0101_0100);
    endfunction

    function automatic logic [31:0] modelTarget(input logic [31:0] t);
`ifdef FETCH_ALIGN_CHK_EN
        return t;
`else
        return t & ~32'h3;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic rdy, input logic redir, input logic [31:0] tgt);
        reset           = rst;
        instr_ready     = rdy;
        redirect        = redir;
        redirect_target = tgt;
    endtask

    // Advance one cycle and let the memory react to what the DUT did at the edge.
    task automatic step();
        logic        sreq, sgnt;
        logic [31:0] saddr;
        @(negedge clk);
        sreq  = imem_req;
        sgnt  = imem_gnt;
        saddr = imem_addr;
        @(posedge clk);
        #1;
        if (imem_rvalid) begin
            mem_pending = 1'b0;
            imem_rvalid = 1'b0;
        end
        if (sreq && sgnt) begin
            mem_pending = 1'b1;
            mem_addr    = saddr;
            mem_cnt     = rv_lat;
            req_age     = 0;
        end else if (sreq) begin
            req_age++;
        end else begin
            req_age = 0;
        end
        if (mem_pending) begin
            if (mem_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = memword(mem_addr);
            end else begin
                mem_cnt--;
            end
        end
    endtask

    // Monitor: the expected PC stream restarts at reset or redirect and advances by 4 per consumed instruction.
    always @(negedge clk) begin
        logic [31:0] e;
        if (reset) begin
            exp_q.delete();
            exp_q.push_back(RESET_PC);
        end else begin
            checkOutput("pc_plus4", pc_plus4, pc + 32'd4);
            if (!instr_valid) checkOutput("idle_instr_nop", instr, NOP_INSTR);
            if (prev_redirect && !prev_reset) checkOutput("valid_after_redirect", 32'(instr_valid), 32'd0);
            if (prev_req && !prev_gnt && !prev_redirect && !prev_reset) begin
                checkOutput("req_held", 32'(imem_req), 32'd1);
                checkOutput("addr_held", imem_addr, prev_addr);
            end
            if (redirect) begin
                exp_q.delete();
                exp_q.push_back(modelTarget(redirect_target));
            end else if (instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL unexpected_delivery: got pc %h expected none", pc);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("deliver_pc", pc, e);
                    checkOutput("deliver_instr", instr, memword(e));
                    exp_q.push_back(e + 32'd4);
                    handshakes++;
                end
            end
        end
        prev_req      = imem_req;
        prev_gnt      = imem_gnt;
        prev_addr     = imem_addr;
        prev_redirect = redirect;
        prev_reset    = reset;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        step();
        step();
        checkOutput("rst_req", 32'(imem_req), 32'd0);
        checkOutput("rst_valid", 32'(instr_valid), 32'd0);
        checkOutput("rst_instr", instr, NOP_INSTR);
        checkOutput("rst_pc", pc, RESET_PC);
        checkOutput("rst_fault", 32'(fetch_fault), 32'd0);

        // Zero-wait memory: valid two cycles after the first request.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        #1;
        checkOutput("c0_req", 32'(imem_req), 32'd1);
        checkOutput("c0_addr", imem_addr, 32'h0);
        step();
        checkOutput("c1_valid", 32'(instr_valid), 32'd0);
        checkOutput("c1_req", 32'(imem_req), 32'd0);
        step();
        checkOutput("c2_valid", 32'(instr_valid), 32'd1);
        checkOutput("c2_pc", pc, 32'h0);
        checkOutput("c2_pc_plus4", pc_plus4, 32'h4);
        checkOutput("c2_instr", instr, 32'h0050_0093);
        gnt_wait = 3;
        rv_lat   = 2;
        step();

        // Slow grant and slow data: address must hold and instr stays NOP until data arrives.
        for (int i = 0; i < 4; i++) begin
            checkOutput("slow_req", 32'(imem_req), 32'd1);
            checkOutput("slow_addr", imem_addr, 32'h4);
            step();
        end
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("wait_valid", 32'(instr_valid), 32'd0);
            checkOutput("wait_req", 32'(imem_req), 32'd0);
            step();
        end

        // Downstream stall holds the instruction.
        for (int i = 0; i < 4; i++) begin
            checkOutput("stall_valid", 32'(instr_valid), 32'd1);
            checkOutput("stall_pc", pc, 32'h4);
            checkOutput("stall_instr", instr, memword(32'h4));
            checkOutput("stall_req", 32'(imem_req), 32'd0);
            step();
        end
        gnt_wait = 0;
        rv_lat   = 0;
        instr_ready = 1'b1;
        step();
        checkOutput("after_stall_pc", pc, 32'h8);
        checkOutput("after_stall_req", 32'(imem_req), 32'd1);
        checkOutput("after_stall_addr", imem_addr, 32'h8);

        // Redirect in the grant cycle: the word for 0x8 is discarded.
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h100);
        step();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("drop_valid", 32'(instr_valid), 32'd0);
        checkOutput("drop_req", 32'(imem_req), 32'd0);
        step();
        checkOutput("redir_req", 32'(imem_req), 32'd1);
        checkOutput("redir_addr", imem_addr, 32'h100);
        step();
        step();
        checkOutput("redir_valid", 32'(instr_valid), 32'd1);
        checkOutput("redir_pc", pc, 32'h100);
        checkOutput("redir_instr", instr, memword(32'h100));

        // Redirect while presenting with ready high beats pc+4.
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h200);
        rv_lat = 2;
        step();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("out_redir_valid", 32'(instr_valid), 32'd0);
        checkOutput("out_redir_pc", pc, 32'h200);
        checkOutput("out_redir_addr", imem_addr, 32'h200);
        step();
        checkOutput("wait2_req", 32'(imem_req), 32'd0);

        // Reset during WAIT; the late response must be ignored.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        step();
        checkOutput("midrst_pc", pc, RESET_PC);
        checkOutput("midrst_req", 32'(imem_req), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        step();
        checkOutput("late_rv_req", 32'(imem_req), 32'd1);
        checkOutput("late_rv_addr", imem_addr, RESET_PC);
        step();
        checkOutput("late_rv_instr", instr, NOP_INSTR);
        checkOutput("late_rv_valid", 32'(instr_valid), 32'd0);
        for (int i = 0; i < 12 && !instr_valid; i++) step();
        checkOutput("post_rst_valid", 32'(instr_valid), 32'd1);
        checkOutput("post_rst_pc", pc, RESET_PC);
        checkOutput("post_rst_instr", instr, memword(RESET_PC));

`ifdef FETCH_ALIGN_CHK_EN
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h102);
        step();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("fault_flag", 32'(fetch_fault), 32'd1);
            checkOutput("fault_req", 32'(imem_req), 32'd0);
            checkOutput("fault_valid", 32'(instr_valid), 32'd0);
            step();
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h104);
        step();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("fault_clear", 32'(fetch_fault), 32'd0);
        for (int i = 0; i < 12 && !imem_req; i++) step();
        checkOutput("fault_exit_req", 32'(imem_req), 32'd1);
        checkOutput("fault_exit_addr", imem_addr, 32'h104);
`else
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h102);
        step();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("noalign_fault", 32'(fetch_fault), 32'd0);
        for (int i = 0; i < 12 && !imem_req; i++) step();
        checkOutput("noalign_req", 32'(imem_req), 32'd1);
        checkOutput("noalign_addr", imem_addr, 32'h100);
`endif

        // Randomized traffic; the monitor does the checking.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] t;
            step();
            t = $urandom_range(0, 32'hFFF);
            if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
`ifdef FETCH_ALIGN_CHK_EN
            t = t & ~32'h3;
`endif
            applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 15) == 0, t);
            gnt_wait = $urandom_range(0, 3);
            rv_lat   = $urandom_range(0, 2);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 10; i++) step();
        checkOutput("enough_handshakes", 32'(handshakes >= 50), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
